// File: rtl/osd_wr_scheduler.sv
// OSD RAM write-port scheduler: round-robin between a toggle-handshaked CPU FIFO and a valid/ready HW writer.
// Optional OSD_WR_VSYNC_GATE_EN restricts grants to cycles with WrWindow_i high.
module osd_wr_scheduler #(
    parameter int OSD_WORD_W      = 20,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       SYS_CLK_i,
    input  logic                       SYS_RST_i,
    input  logic [OSD_WORD_W:0]        CPU_WrVector_i,
    input  logic                       HW_Valid_i,
    input  logic [OSD_WORD_W-1:0]      HW_Word_i,
    output logic                       HW_Ready_o,
    input  logic                       WrWindow_i,
    input  logic                       Clr_Ovf_i,
    output logic                       OSD_WrEn_o,
    output logic [OSD_WORD_W-1:0]      OSD_WrWord_o,
    output logic [FIFO_DEPTH_LOG2:0]   FIFO_Level_o,
    output logic                       Ovf_o
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] LVL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    // rr_pref | meaning
    // CPU     | CPU wins when both sides request
    // HW      | HW wins when both sides request
    typedef enum logic {
        SIDE_CPU = 1'b0,
        SIDE_HW  = 1'b1
    } side_t;

    side_t                      rr_pref;
    logic [OSD_WORD_W-1:0]      fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   level;
    logic                       prev_toggle;

    logic window_open;
    logic arb_en;
    logic req_cpu;
    logic req_hw;
    logic grant_cpu;
    logic grant_hw;
    logic push_req;
    logic fifo_full;
    logic push_ok;
    logic drop;

`ifdef OSD_WR_VSYNC_GATE_EN
    assign window_open = WrWindow_i;
`else
    logic unused_wr_window;
    assign unused_wr_window = WrWindow_i;
    assign window_open      = 1'b1;
`endif

    // Reset also blocks grants so HW is never told its word was taken in a discarded cycle.
    assign arb_en    = window_open & ~SYS_RST_i;
    assign req_cpu   = (level != '0);
    assign req_hw    = HW_Valid_i;
    assign grant_cpu = arb_en & req_cpu & (~req_hw | (rr_pref == SIDE_CPU));
    assign grant_hw  = arb_en & req_hw & (~req_cpu | (rr_pref == SIDE_HW));
    assign HW_Ready_o = grant_hw;

    assign push_req  = CPU_WrVector_i[OSD_WORD_W] ^ prev_toggle;
    assign fifo_full = (level == LVL_FULL);
    assign push_ok   = push_req & (~fifo_full | grant_cpu);
    assign drop      = push_req & fifo_full & ~grant_cpu;

    assign FIFO_Level_o = level;

    always_ff @(posedge SYS_CLK_i) begin
        if (push_ok && !SYS_RST_i) begin
            fifo_mem[wr_ptr] <= CPU_WrVector_i[OSD_WORD_W-1:0];
        end
    end

    always_ff @(posedge SYS_CLK_i) begin
        if (SYS_RST_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            prev_toggle  <= CPU_WrVector_i[OSD_WORD_W];
            rr_pref      <= SIDE_CPU;
            OSD_WrEn_o   <= 1'b0;
            OSD_WrWord_o <= '0;
            Ovf_o        <= 1'b0;
        end else begin
            prev_toggle <= CPU_WrVector_i[OSD_WORD_W];
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_cpu) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, grant_cpu})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            Ovf_o      <= drop | (Ovf_o & ~Clr_Ovf_i);
            OSD_WrEn_o <= grant_cpu | grant_hw;
            if (grant_cpu) begin
                OSD_WrWord_o <= fifo_mem[rd_ptr];
                rr_pref      <= SIDE_HW;
            end else if (grant_hw) begin
                OSD_WrWord_o <= HW_Word_i;
                rr_pref      <= SIDE_CPU;
            end
        end
    end

endmodule

// File: tb/tb_osd_wr_scheduler.sv
// Bench for osd_wr_scheduler: queue-based reference model compared every cycle, plus directed literal checks.
module tb_osd_wr_scheduler;

    localparam int W     = 20;
    localparam int L     = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W:0]     vec;
    logic           hw_valid;
    logic [W-1:0]   hw_word;
    logic           hw_ready;
    logic           win;
    logic           clr;
    logic           wren;
    logic [W-1:0]   word;
    logic [L:0]     level;
    logic           ovf;

    always #5 clk = ~clk;

    osd_wr_scheduler #(.OSD_WORD_W(W), .FIFO_DEPTH_LOG2(L)) dut (
        .SYS_CLK_i      (clk),
        .SYS_RST_i      (rst),
        .CPU_WrVector_i (vec),
        .HW_Valid_i     (hw_valid),
        .HW_Word_i      (hw_word),
        .HW_Ready_o     (hw_ready),
        .WrWindow_i     (win),
        .Clr_Ovf_i      (clr),
        .OSD_WrEn_o     (wren),
        .OSD_WrWord_o   (word),
        .FIFO_Level_o   (level),
        .Ovf_o          (ovf)
    );

    int checks   = 0;
    int failures = 0;
    logic tog;

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_prev;
    bit           m_pref_hw;
    bit           m_wren;
    logic [W-1:0] m_word;
    bit           m_ovf;
    bit           gh_last;

    logic [W-1:0] w3 [8] = '{20'h1F0FF, 20'h00B01, 20'h1F0FF, 20'h00B02,
                             20'h1F0FF, 20'h00B03, 20'h1F0FF, 20'h00B04};
    bit           r3 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at the falling edge: inputs for this cycle are stable; compare, then advance to the next edge.
    task automatic model_cycle(input bit do_cmp);
        bit win_o, en, rc, rh, gc, gh, push, full, drop;
`ifdef OSD_WR_VSYNC_GATE_EN
        win_o = win;
`else
        win_o = 1'b1;
`endif
        en = win_o && !rst;
        rc = (q.size() > 0);
        rh = hw_valid;
        gc = en && rc && (!rh || !m_pref_hw);
        gh = en && rh && (!rc || m_pref_hw);
        gh_last = gh;
        if (do_cmp) begin
            chk("hw_ready", 32'(hw_ready), 32'(gh));
            chk("wr_en",    32'(wren),     32'(m_wren));
            chk("wr_word",  32'(word),     32'(m_word));
            chk("level",    32'(level),    32'(q.size()));
            chk("ovf",      32'(ovf),      32'(m_ovf));
        end
        if (rst) begin
            q.delete();
            m_prev    = vec[W];
            m_wren    = 1'b0;
            m_word    = '0;
            m_ovf     = 1'b0;
            m_pref_hw = 1'b0;
        end else begin
            push   = (vec[W] != m_prev);
            m_prev = vec[W];
            full   = (q.size() == DEPTH);
            drop   = push && full && !gc;
            m_wren = gc || gh;
            if (gc) m_word = q.pop_front();
            else if (gh) m_word = hw_word;
            if (push && !drop) q.push_back(vec[W-1:0]);
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (gc) m_pref_hw = 1'b1;
            else if (gh) m_pref_hw = 1'b0;
        end
    endtask

    task automatic step(input bit do_cmp);
        @(negedge clk);
        model_cycle(do_cmp);
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        tog = ~tog;
        vec = {tog, w};
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tog      = 1'b1;
        vec      = {1'b1, 20'h0};
        hw_valid = 1'b0;
        hw_word  = 20'h1F0FF;
        win      = 1'b1;
        clr      = 1'b0;
        rst      = 1'b1;
        step(0);
        step(1);
        rst = 1'b0;

        // 1: reset release with toggle MSB held high
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t1_level", 32'(level), 32'd0);
            chk("t1_wren",  32'(wren),  32'd0);
        end

        // 2: three CPU words drain back to back
        push_word(20'h00A41); step(1);
        chk("t2_wren0", 32'(wren), 32'd0);
        push_word(20'h00A42); step(1);
        chk("t2_word1", 32'(word), 32'h00A41);
        chk("t2_wren1", 32'(wren), 32'd1);
        push_word(20'h00A43); step(1);
        chk("t2_word2", 32'(word), 32'h00A42);
        step(1);
        chk("t2_word3", 32'(word), 32'h00A43);
        chk("t2_wren3", 32'(wren), 32'd1);
        step(1);
        chk("t2_wren_end",  32'(wren),  32'd0);
        chk("t2_level_end", 32'(level), 32'd0);

        // 3: CPU and HW alternate
        hw_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) push_word(20'h00B01 + 20'(i));
            step(1);
            chk("t3_ready", 32'(gh_last), 32'(r3[i]));
            chk("t3_word",  32'(word),    32'(w3[i]));
            chk("t3_wren",  32'(wren),    32'd1);
        end
        hw_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(1);

        // 4: fill against HW traffic, full+pop push, overflow, clear
        hw_valid = 1'b1;
        for (int i = 0; i < 100 && q.size() < DEPTH; i++) begin
            push_word(20'h0C000 + 20'(i));
            step(1);
        end
        chk("t4_full_level", 32'(level), 32'd16);
        chk("t4_full_ovf",   32'(ovf),   32'd0);
        hw_valid = 1'b0;
        push_word(20'h0D001); step(1);
        chk("t4_pushpop_level", 32'(level), 32'd16);
        chk("t4_pushpop_ovf",   32'(ovf),   32'd0);
        hw_valid = 1'b1;
        push_word(20'h0D002); step(1);
        chk("t4_drop_level", 32'(level), 32'd16);
        chk("t4_drop_ovf",   32'(ovf),   32'd1);
        hw_valid = 1'b0;
        clr = 1'b1; step(1);
        clr = 1'b0;
        chk("t4_clr_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 20; i++) step(1);
        chk("t4_drained", 32'(level), 32'd0);

`ifdef OSD_WR_VSYNC_GATE_EN
        // 5: closed window blocks all grants but still accepts pushes
        win = 1'b0;
        hw_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 2) push_word(20'h0E001 + 20'(i));
            step(1);
            chk("t5_wren_closed",  32'(wren),    32'd0);
            chk("t5_ready_closed", 32'(gh_last), 32'd0);
        end
        chk("t5_level_closed", 32'(level), 32'd2);
        win = 1'b1;
        step(1);
        chk("t5_wren_open", 32'(wren), 32'd1);
        hw_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(1);
`endif

        // 6: reset with words queued discards them
        hw_valid = 1'b1;
        for (int i = 0; i < 40 && q.size() < 5; i++) begin
            push_word(20'h0F000 + 20'(i));
            step(1);
        end
        chk("t6_queued", 32'(level), 32'd5);
        rst = 1'b1; step(1);
        rst = 1'b0;
        hw_valid = 1'b0;
        chk("t6_level_rst", 32'(level), 32'd0);
        chk("t6_wren_rst",  32'(wren),  32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t6_no_write", 32'(wren), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
